// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - title/play/over screen sequencer with frame-aligned pixel source mux
// Optional fade-in on screen change: define SCREEN_FADE_EN.
module screen_sequencer #(
   parameter int BLINK_FRAMES     = 30,
   parameter int PROMPT_Y0        = 400,
   parameter int PROMPT_Y1        = 431,
   parameter int OVER_HOLD_FRAMES = 180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  x,
   input  logic [8:0]  y,
   input  logic        video_on,
   input  logic        frame_tick,
   input  logic        start_btn,
   input  logic        game_over,
   input  logic [11:0] title_pix,
   input  logic [11:0] game_pix,
   input  logic [11:0] over_pix,
   output logic [11:0] pix_out,
   output logic [1:0]  screen_sel,
   output logic        game_run,
   output logic        game_clear
);

   typedef enum logic [1:0] {
      S_TITLE = 2'd0,
      S_PLAY  = 2'd1,
      S_OVER  = 2'd2,
      S_BAD   = 2'd3
   } state_t;

   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;
   localparam int HW = (OVER_HOLD_FRAMES > 1) ? $clog2(OVER_HOLD_FRAMES + 1) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(OVER_HOLD_FRAMES);
   localparam logic [8:0]    BAND_Y0    = 9'(PROMPT_Y0);
   localparam logic [8:0]    BAND_Y1    = 9'(PROMPT_Y1);

   state_t          r_state, w_next;
   logic            r_start_q, r_start_req, w_req_next, w_clear;
   logic            r_game_run, r_game_clear;
   logic [BW-1:0]   r_blink_cnt;
   logic            r_blink_phase;
   logic [HW-1:0]   r_hold;
   logic [11:0]     r_pix, w_pix_sel, w_pix;
   logic            w_start_edge, w_req_now, w_visible, w_in_band;

   assign w_start_edge = start_btn & ~r_start_q;
   // An edge arriving with the tick itself is honoured by that tick.
   assign w_req_now    = r_start_req | w_start_edge;
   assign w_visible    = video_on && (x < 10'd640) && (y < 9'd480);
   assign w_in_band    = (y >= BAND_Y0) && (y <= BAND_Y1);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_TITLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_clear    = 1'b0;
      w_req_next = r_start_req;
      case (r_state)
         S_TITLE: begin
            w_req_next = w_req_now;
            if (frame_tick && w_req_now) begin
               w_next     = S_PLAY;
               w_clear    = 1'b1;
               w_req_next = 1'b0;
            end
         end
         S_PLAY: begin
            w_req_next = 1'b0;
            if (frame_tick && game_over) w_next = S_OVER;
         end
         S_OVER: begin
            w_req_next = 1'b0;
            if (r_hold == HOLD_MAX) begin
               w_req_next = w_req_now;
               if (frame_tick && w_req_now) begin
                  w_next     = S_TITLE;
                  w_req_next = 1'b0;
               end
            end
         end
         default: begin
            w_next     = S_TITLE;
            w_req_next = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_pix_sel = 12'h000;
      if (w_visible) begin
         case (r_state)
            S_TITLE: w_pix_sel = (r_blink_phase && w_in_band) ? 12'h000 : title_pix;
            S_PLAY:  w_pix_sel = game_pix;
            S_OVER:  w_pix_sel = over_pix;
            default: w_pix_sel = 12'h000;
         endcase
      end
   end

`ifdef SCREEN_FADE_EN
   logic [4:0] r_level;

   function automatic logic [3:0] scale_nib(input logic [3:0] n, input logic [4:0] lvl);
      logic [7:0] p;
      p = {4'd0, n} * {3'd0, lvl};
      return 4'(p >> 4);
   endfunction

   always_ff @(posedge clk) begin
      if (reset)                              r_level <= 5'd16;
      else if (w_next != r_state)             r_level <= 5'd0;
      else if (frame_tick && r_level != 5'd16) r_level <= r_level + 5'd1;
   end

   assign w_pix = {scale_nib(w_pix_sel[11:8], r_level),
                   scale_nib(w_pix_sel[7:4],  r_level),
                   scale_nib(w_pix_sel[3:0],  r_level)};
`else
   assign w_pix = w_pix_sel;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_start_q     <= 1'b0;
         r_start_req   <= 1'b0;
         r_game_run    <= 1'b0;
         r_game_clear  <= 1'b0;
         r_pix         <= 12'h000;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_hold        <= '0;
      end else begin
         r_start_q    <= start_btn;
         r_start_req  <= w_req_next;
         r_game_run   <= (w_next == S_PLAY);
         r_game_clear <= w_clear;
         r_pix        <= w_pix;
         if (w_next == S_TITLE && r_state != S_TITLE) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
         end else if (r_state == S_TITLE && frame_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
               r_blink_cnt   <= '0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + 1'b1;
            end
         end
         if (w_next == S_OVER && r_state != S_OVER)
            r_hold <= '0;
         else if (r_state == S_OVER && frame_tick && r_hold != HOLD_MAX)
            r_hold <= r_hold + 1'b1;
      end
   end

   assign pix_out    = r_pix;
   assign screen_sel = r_state;
   assign game_run   = r_game_run;
   assign game_clear = r_game_clear;

endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - directed vector bench for screen_sequencer
module tb_screen_sequencer;

   localparam logic [11:0] TP = 12'hABC;
   localparam logic [11:0] GP = 12'h123;
   localparam logic [11:0] OP = 12'h456;
   localparam logic [8:0]  YO = 9'd300;
   localparam logic [8:0]  YB = 9'd410;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  x = 10'd100;
   logic [8:0]  y = 9'd300;
   logic        video_on = 1'b1;
   logic        frame_tick = 1'b0;
   logic        start_btn = 1'b0;
   logic        game_over = 1'b0;
   logic [11:0] title_pix = TP;
   logic [11:0] game_pix = GP;
   logic [11:0] over_pix = OP;
   logic [11:0] pix_out;
   logic [1:0]  screen_sel;
   logic        game_run;
   logic        game_clear;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        rst, tick, btn, gov, von;
      logic [8:0]  yy;
      logic [1:0]  sel;
      logic        run, clr;
      logic [11:0] pix;
   } vec_t;

   vec_t tbl[$];

   screen_sequencer #(
      .BLINK_FRAMES(2), .PROMPT_Y0(400), .PROMPT_Y1(431), .OVER_HOLD_FRAMES(10)
   ) dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
      .frame_tick(frame_tick), .start_btn(start_btn), .game_over(game_over),
      .title_pix(title_pix), .game_pix(game_pix), .over_pix(over_pix),
      .pix_out(pix_out), .screen_sel(screen_sel), .game_run(game_run),
      .game_clear(game_clear)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, input logic tick, input logic btn,
                               input logic gov, input logic von, input logic [8:0] yy,
                               input logic [1:0] sel, input logic run, input logic clr,
                               input logic [11:0] pix);
      vec_t v;
      v.rst = rst; v.tick = tick; v.btn = btn; v.gov = gov; v.von = von; v.yy = yy;
      v.sel = sel; v.run = run; v.clr = clr; v.pix = pix;
      return v;
   endfunction

   task automatic apply(input string tag, input vec_t v);
      reset = v.rst; frame_tick = v.tick; start_btn = v.btn;
      game_over = v.gov; video_on = v.von; y = v.yy;
      @(posedge clk);
      #1;
      n_vec++;
      if (screen_sel !== v.sel || game_run !== v.run || game_clear !== v.clr || pix_out !== v.pix) begin
         n_err++;
         $display("FAIL %s: got sel=%0d run=%0b clr=%0b pix=%03h, expected sel=%0d run=%0b clr=%0b pix=%03h",
                  tag, screen_sel, game_run, game_clear, pix_out, v.sel, v.run, v.clr, v.pix);
      end
   endtask

   initial begin
      //                 rst  tick btn  gov  von  y    sel  run  clr  pix
      tbl.push_back(mk(1, 0, 0, 0, 1, YO, 0, 0, 0, 12'h000)); // reset state
      tbl.push_back(mk(0, 0, 0, 0, 1, YO, 0, 0, 0, TP));
      tbl.push_back(mk(0, 1, 0, 0, 1, YO, 0, 0, 0, TP));
      tbl.push_back(mk(0, 0, 0, 0, 1, YO, 0, 0, 0, TP));
      tbl.push_back(mk(0, 1, 0, 0, 1, YO, 0, 0, 0, TP));      // blink wraps -> phase 1
      tbl.push_back(mk(0, 0, 0, 0, 1, YB, 0, 0, 0, 12'h000)); // prompt band blanked
      tbl.push_back(mk(0, 0, 0, 0, 1, YO, 0, 0, 0, TP));
      tbl.push_back(mk(0, 1, 0, 0, 1, YO, 0, 0, 0, TP));
      tbl.push_back(mk(0, 1, 0, 0, 1, YB, 0, 0, 0, 12'h000)); // phase back to 0
      tbl.push_back(mk(0, 0, 0, 0, 1, YB, 0, 0, 0, TP));
      tbl.push_back(mk(0, 0, 0, 0, 0, YO, 0, 0, 0, 12'h000)); // blanking
      tbl.push_back(mk(0, 0, 1, 0, 1, YO, 0, 0, 0, TP));      // press mid-frame
      tbl.push_back(mk(0, 0, 0, 0, 1, YO, 0, 0, 0, TP));
      tbl.push_back(mk(0, 1, 0, 0, 1, YO, 1, 1, 1, TP));      // enter PLAY
      tbl.push_back(mk(0, 0, 0, 0, 1, YO, 1, 1, 0, GP));
      tbl.push_back(mk(0, 0, 1, 0, 1, YO, 1, 1, 0, GP));      // ignored in PLAY
      tbl.push_back(mk(0, 1, 0, 0, 1, YO, 1, 1, 0, GP));
      tbl.push_back(mk(0, 0, 0, 1, 1, YO, 1, 1, 0, GP));      // game_over waits for tick
      tbl.push_back(mk(0, 1, 0, 1, 1, YO, 2, 0, 0, GP));      // enter OVER
      tbl.push_back(mk(0, 0, 0, 0, 1, YO, 2, 0, 0, OP));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 0, 0, 1, YO, 2, 0, 0, OP));
      tbl.push_back(mk(0, 0, 1, 0, 1, YO, 2, 0, 0, OP));      // press at hold 5: discarded
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 1, 0, 1, YO, 2, 0, 0, OP));
      tbl.push_back(mk(0, 1, 1, 0, 1, YO, 2, 0, 0, OP));      // held button, no new edge
      tbl.push_back(mk(0, 0, 0, 0, 1, YO, 2, 0, 0, OP));
      tbl.push_back(mk(0, 0, 1, 0, 1, YO, 2, 0, 0, OP));      // accepted press
      tbl.push_back(mk(0, 0, 0, 0, 1, YO, 2, 0, 0, OP));
      tbl.push_back(mk(0, 1, 0, 0, 1, YO, 0, 0, 0, OP));      // back to TITLE
      tbl.push_back(mk(0, 0, 0, 0, 1, YB, 0, 0, 0, TP));
      tbl.push_back(mk(0, 1, 1, 1, 1, YO, 1, 1, 1, TP));      // edge with tick, game_over high
      tbl.push_back(mk(0, 0, 1, 1, 1, YO, 1, 1, 0, GP));
      tbl.push_back(mk(0, 1, 1, 1, 1, YO, 2, 0, 0, GP));      // leaves on first tick
      tbl.push_back(mk(0, 0, 0, 0, 1, YO, 2, 0, 0, OP));

      for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

      // reset mid-frame while in PLAY
      apply("rp_rst",   mk(1, 0, 0, 0, 1, YO, 0, 0, 0, 12'h000));
      apply("rp_enter", mk(0, 1, 1, 0, 1, YO, 1, 1, 1, TP));
      apply("rp_play",  mk(0, 0, 0, 0, 1, YO, 1, 1, 0, GP));
      apply("rp_reset", mk(1, 0, 0, 0, 1, YO, 0, 0, 0, 12'h000));
      apply("rp_after", mk(0, 0, 0, 0, 1, YO, 0, 0, 0, TP));

      // pending request must not survive reset
      apply("pr_press", mk(0, 0, 1, 0, 1, YO, 0, 0, 0, TP));
      apply("pr_reset", mk(1, 0, 0, 0, 1, YO, 0, 0, 0, 12'h000));
      apply("pr_tick",  mk(0, 1, 0, 0, 1, YO, 0, 0, 0, TP));
      apply("pr_idle",  mk(0, 0, 0, 0, 1, YO, 0, 0, 0, TP));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
